// File: rtl/alu_exec_stage.sv
// Execute-stage wrapper around the combinational Arithmetic unit: handshaked issue, latency hold, flags, writeback.
// Optional divide-by-zero trap state enabled by defining ALU_EXEC_DIVZERO_TRAP_EN.
package alu_exec_pkg;
  typedef enum logic [3:0] {
    NOP  = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    INC  = 4'd3,
    DEC  = 4'd4,
    MUL  = 4'd5,
    UDIV = 4'd6,
    SDIV = 4'd7,
    UMOD = 4'd8,
    SMOD = 4'd9
  } opcode_t;

  typedef logic [63:0] ulong_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
  } flags_t;
endpackage

module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  opcode_t       in_op,
  input  ulong_t        in_a,
  input  ulong_t        in_b,
  input  logic [4:0]    in_dest,
  output opcode_t       alu_op,
  output logic          alu_carryIn,
  output logic [63:0]   alu_a,
  output logic [63:0]   alu_b,
  input  logic [63:0]   alu_result,
  input  logic          alu_divByZero,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_negitive,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [4:0]    wb_dest,
  output logic [63:0]   wb_data,
  output logic          flag_zero,
  output logic          flag_carry,
  output logic          flag_negitive,
  output logic          trap_valid,
  input  logic          trap_ack,
  output logic          busy
);
  localparam int unsigned MaxLat = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

`ifdef ALU_EXEC_DIVZERO_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_TRAP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
`endif

  function automatic logic is_div(opcode_t op);
    return op inside {UDIV, SDIV, UMOD, SMOD};
  endfunction

  function automatic logic is_arith(opcode_t op);
    return op inside {ADD, SUB, INC, DEC, MUL, UDIV, SDIV, UMOD, SMOD};
  endfunction

  function automatic logic [CntW-1:0] lat_m1(opcode_t op);
    if (is_div(op))     return CntW'(DIV_LATENCY - 1);
    else if (op == MUL) return CntW'(MUL_LATENCY - 1);
    else                return '0;
  endfunction

  state_e           state_q, state_d;
  opcode_t          op_q, op_d;
  logic [63:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0]       dest_q, dest_d;
  logic             cin_q, cin_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  flags_t           hold_q, hold_d, flags_q, flags_d;
  logic             div_zero_c;

  assign div_zero_c = is_div(op_q) && alu_divByZero;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid && is_arith(in_op)) state_d = S_EXEC;
      S_EXEC: if (cnt_q == '0) begin
`ifdef ALU_EXEC_DIVZERO_TRAP_EN
        state_d = div_zero_c ? S_TRAP : S_WB;
`else
        state_d = S_WB;
`endif
      end
      S_WB:   if (wb_ready) state_d = S_IDLE;
`ifdef ALU_EXEC_DIVZERO_TRAP_EN
      S_TRAP: if (trap_ack) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b1;
    alu_op      = NOP;
    alu_a       = '0;
    alu_b       = '0;
    alu_carryIn = 1'b0;
    wb_valid    = 1'b0;
    wb_dest     = '0;
    wb_data     = '0;
    trap_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_EXEC: begin
        alu_op      = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        alu_carryIn = cin_q;
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_dest  = dest_q;
        wb_data  = res_q;
      end
`ifdef ALU_EXEC_DIVZERO_TRAP_EN
      S_TRAP: trap_valid = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath: latch on accept, count down in EXEC, capture at zero, commit flags on writeback.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hold_d  = hold_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: if (in_valid && is_arith(in_op)) begin
        op_d   = in_op;
        a_d    = in_a;
        b_d    = in_b;
        dest_d = in_dest;
        cin_d  = flags_q.c;
        cnt_d  = lat_m1(in_op);
      end
      S_EXEC: if (cnt_q == '0) begin
        if (div_zero_c) begin
          res_d  = '0;
          hold_d = '{z: 1'b1, c: 1'b0, n: 1'b0};
        end else begin
          res_d  = alu_result;
          hold_d = '{z: alu_zero, c: alu_carry, n: alu_negitive};
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
      S_WB: if (wb_ready) flags_d = hold_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      hold_q  <= '0;
      flags_q <= '0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hold_q  <= hold_d;
      flags_q <= flags_d;
    end
  end

  assign flag_zero     = flags_q.z;
  assign flag_carry    = flags_q.c;
  assign flag_negitive = flags_q.n;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, hand-written corner sequences, randomized ops vs model.
module tb_alu_exec_stage;
  import alu_exec_pkg::*;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  opcode_t     in_op;
  ulong_t      in_a, in_b;
  logic [4:0]  in_dest;
  opcode_t     alu_op;
  logic        alu_carryIn;
  logic [63:0] alu_a, alu_b, alu_result;
  logic        alu_divByZero, alu_zero, alu_carry, alu_negitive;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_dest;
  logic [63:0] wb_data;
  logic        flag_zero, flag_carry, flag_negitive;
  logic        trap_valid, trap_ack, busy;

  alu_exec_stage #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
    .alu_op(alu_op), .alu_carryIn(alu_carryIn), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_divByZero(alu_divByZero), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_negitive(alu_negitive),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_negitive(flag_negitive),
    .trap_valid(trap_valid), .trap_ack(trap_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] r;
    logic        z, c, n, dz;
  } alu_out_t;

  // Behavioural Arithmetic unit: plain integer arithmetic on the operands.
  function automatic alu_out_t alu_ref(opcode_t op, logic [63:0] a, logic [63:0] b, logic cin);
    alu_out_t o;
    logic [64:0] s;
    o = '0;
    case (op)
      ADD:  begin s = {1'b0, a} + {1'b0, b} + 65'(cin); o.r = s[63:0]; o.c = s[64]; end
      SUB:  begin o.r = a - b; o.c = (a < b); end
      INC:  begin o.r = a + 64'd1; o.c = (a == '1); end
      DEC:  begin o.r = a - 64'd1; o.c = (a == '0); end
      MUL:  o.r = a * b;
      UDIV: if (b == '0) begin o.dz = 1'b1; o.r = '1; end else o.r = a / b;
      UMOD: if (b == '0) begin o.dz = 1'b1; o.r = a; end else o.r = a % b;
      SDIV: if (b == '0) begin o.dz = 1'b1; o.r = '1; end
            else if (a == 64'h8000_0000_0000_0000 && b == '1) o.r = a;
            else o.r = 64'($signed(a) / $signed(b));
      SMOD: if (b == '0) begin o.dz = 1'b1; o.r = a; end
            else if (a == 64'h8000_0000_0000_0000 && b == '1) o.r = '0;
            else o.r = 64'($signed(a) % $signed(b));
      default: ;
    endcase
    o.z = (o.r == '0);
    o.n = o.r[63];
    return o;
  endfunction

  alu_out_t ao;
  always_comb ao = alu_ref(alu_op, alu_a, alu_b, alu_carryIn);
  assign alu_result    = ao.r;
  assign alu_zero      = ao.z;
  assign alu_carry     = ao.c;
  assign alu_negitive  = ao.n;
  assign alu_divByZero = ao.dz;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_z, m_c, m_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, then follow it to writeback/trap completion.
  task automatic issue(input opcode_t op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] dest,
                       input int hold, input logic exp_cin,
                       output int kind, output int lat, output logic [63:0] data, output logic [4:0] wdest,
                       output logic stable);
    stable = 1'b1; kind = 0; lat = 0; data = '0; wdest = '0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dest = dest;
    if (!in_ready) stable = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_op = NOP; in_a = '0; in_b = '0; in_dest = '0;
    for (int c = 1; c < 200; c++) begin
      if (wb_valid || trap_valid) begin
        lat = c;
        break;
      end
      if (alu_op != op || alu_a != a || alu_b != b || alu_carryIn != exp_cin || in_ready || !busy) stable = 1'b0;
      @(negedge clk);
    end
    if (lat != 0) begin
      kind  = wb_valid ? 1 : 2;
      data  = wb_data;
      wdest = wb_dest;
      for (int h = 0; h < hold; h++) begin
        if (wb_data != data || wb_dest != wdest || in_ready || alu_op != NOP || alu_a != '0 ||
            !(wb_valid || trap_valid)) stable = 1'b0;
        @(negedge clk);
      end
      wb_ready = (kind == 1);
      trap_ack = (kind == 2);
      @(negedge clk);
      wb_ready = 1'b0;
      trap_ack = 1'b0;
      if (!in_ready || busy || wb_valid || trap_valid) stable = 1'b0;
    end
  endtask

  task automatic predict(input opcode_t op, input logic [63:0] a, input logic [63:0] b,
                         output int ekind, output int elat, output logic [63:0] edata,
                         output logic ez, output logic ec, output logic en);
    alu_out_t o;
    logic dv;
    o = alu_ref(op, a, b, m_c);
    dv = op inside {UDIV, SDIV, UMOD, SMOD};
    elat = dv ? int'(DIV_LAT) + 1 : (op == MUL ? int'(MUL_LAT) + 1 : 2);
    ekind = 1; edata = o.r; ez = o.z; ec = o.c; en = o.n;
    if (dv && o.dz) begin
`ifdef ALU_EXEC_DIVZERO_TRAP_EN
      ekind = 2; edata = '0; ez = m_z; ec = m_c; en = m_n;
`else
      edata = '0; ez = 1'b1; ec = 1'b0; en = 1'b0;
`endif
    end
  endtask

  task automatic run_check(input string tag, input opcode_t op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] dest, input int hold, input int ekind, input int elat,
                           input logic [63:0] edata, input logic ez, input logic ec, input logic en);
    int kind, lat;
    logic [63:0] data;
    logic [4:0] wdest;
    logic stable;
    issue(op, a, b, dest, hold, m_c, kind, lat, data, wdest, stable);
    chk({tag, " kind"}, 64'(kind), 64'(ekind));
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " wb_data"}, data, edata);
    chk({tag, " wb_dest"}, 64'(wdest), (ekind == 1) ? 64'(dest) : 64'd0);
    chk({tag, " stable"}, 64'(stable), 64'd1);
    chk({tag, " flags"}, 64'({flag_zero, flag_carry, flag_negitive}), 64'({ez, ec, en}));
    m_z = ez; m_c = ec; m_n = en;
  endtask

  typedef struct {
    opcode_t     op;
    logic [63:0] a, b;
    int          hold;
    int          lat;
    logic [63:0] data;
    logic        z, c, n;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ek, el;
    logic [63:0] ed, ra, rb;
    logic ez, ec, en;
    opcode_t rop;
    opcode_t ops[9];

    tbl[0]  = '{ADD,  64'd1, 64'd2, 0, 2, 64'd3, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{ADD,  '1, 64'd1, 0, 2, 64'd0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{ADD,  64'd1, 64'd2, 0, 2, 64'd4, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{SUB,  64'd5, 64'd7, 1, 2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{INC,  '1, 64'd0, 0, 2, 64'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{DEC,  64'd0, 64'd0, 0, 2, '1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{MUL,  64'd2, 64'd3, 3, 3, 64'd6, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{UDIV, 64'd6, 64'd2, 0, 5, 64'd3, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{UMOD, 64'd7, 64'd3, 2, 5, 64'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{SMOD, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 5, '1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 2, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
    ops = '{ADD, SUB, INC, DEC, MUL, UDIV, SDIV, UMOD, SMOD};

    reset = 1'b1; in_valid = 1'b0; in_op = NOP; in_a = '0; in_b = '0; in_dest = '0;
    wb_ready = 1'b0; trap_ack = 1'b0;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset busy/wb/trap", 64'({busy, wb_valid, trap_valid}), 64'd0);
    chk("reset flags", 64'({flag_zero, flag_carry, flag_negitive}), 64'd0);
    chk("reset alu_op", 64'(alu_op), 64'(NOP));

    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].hold,
                1, tbl[i].lat, tbl[i].data, tbl[i].z, tbl[i].c, tbl[i].n);

    // Divide by zero with flags 0/0/1 left by the last vector.
`ifdef ALU_EXEC_DIVZERO_TRAP_EN
    run_check("udiv0", UDIV, 64'd6, 64'd0, 5'd20, 2, 2, 5, 64'd0, 1'b0, 1'b0, 1'b1);
`else
    run_check("udiv0", UDIV, 64'd6, 64'd0, 5'd20, 2, 1, 5, 64'd0, 1'b1, 1'b0, 1'b0);
`endif

    // NOP and an unrecognised opcode are swallowed in IDLE.
    in_valid = 1'b1; in_op = NOP; in_dest = 5'd3;
    @(negedge clk);
    in_op = opcode_t'(4'hF);
    @(negedge clk);
    in_valid = 1'b0; in_op = NOP;
    chk("nop idle", 64'({in_ready, busy}), 64'b10);
    begin
      logic seen = 1'b0;
      repeat (6) begin
        if (wb_valid || trap_valid || busy) seen = 1'b1;
        @(negedge clk);
      end
      chk("nop no activity", 64'(seen), 64'd0);
    end
    chk("nop flags", 64'({flag_zero, flag_carry, flag_negitive}), 64'({m_z, m_c, m_n}));

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 8)];
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 64'($urandom_range(1, 9));
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) ra = 64'($urandom_range(0, 50));
      predict(rop, ra, rb, ek, el, ed, ez, ec, en);
      run_check($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
                ek, el, ed, ez, ec, en);
    end

    // Set carry, then reset in the middle of an SDIV.
    predict(ADD, '1, 64'd1, ek, el, ed, ez, ec, en);
    run_check("preset add", ADD, '1, 64'd1, 5'd9, 0, ek, el, ed, ez, ec, en);
    in_valid = 1'b1; in_op = SDIV; in_a = 64'd100; in_b = 64'd7; in_dest = 5'd4;
    @(negedge clk);
    in_valid = 1'b0; in_op = NOP; in_a = '0; in_b = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset busy/wb/trap", 64'({busy, wb_valid, trap_valid}), 64'd0);
    chk("midreset flags", 64'({flag_zero, flag_carry, flag_negitive}), 64'd0);
    chk("midreset alu_a", alu_a, 64'd0);
    begin
      logic seen = 1'b0;
      repeat (8) begin
        if (wb_valid || trap_valid) seen = 1'b1;
        @(negedge clk);
      end
      chk("midreset no wb", 64'(seen), 64'd0);
    end
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
    run_check("post reset add", ADD, 64'd1, 64'd2, 5'd1, 0, 1, 2, 64'd3, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Sequential execute-stage wrapper that issues decoded arithmetic operations to the combinational `Arithmetic` unit and retires them. Accepts one operation at a time over a valid/ready handshake, holds ALU operands stable for an opcode-dependent latency, and captures result and flags. Owns the architectural flags register (zero/carry/negitive) and feeds `carry` back as the ALU `carryIn`. Presents results on a valid/ready writeback port toward the register file.

## Interface
- `MUL_LATENCY`, 2: execute cycles for MUL (≥1).
- `DIV_LATENCY`, 4: execute cycles for UDIV/SDIV/UMOD/SMOD (≥1).
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `in_valid` / `in_ready`  in/out  1  operation handshake.
- `in_op`  in  opcode_t  operation.
- `in_a`, `in_b`  in  ulong_t (64)  operands.
- `in_dest`  in  5  destination register index.
- `alu_op`  out  opcode_t  to Arithmetic.
- `alu_carryIn`  out  1  to Arithmetic.
- `alu_a`, `alu_b`  out  64  to Arithmetic.
- `alu_result`  in  64  from Arithmetic.
- `alu_divByZero`, `alu_zero`, `alu_carry`, `alu_negitive`  in  1  from Arithmetic.
- `wb_valid` / `wb_ready`  out/in  1  writeback handshake.
- `wb_dest`  out  5  writeback register index.
- `wb_data`  out  64  writeback value.
- `flag_zero`, `flag_carry`, `flag_negitive`  out  1  architectural flags.
- `trap_valid` / `trap_ack`  out/in  1  divide-by-zero trap handshake.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, WB, TRAP.
- IDLE: `in_ready`=1. On `in_valid`: latch op/a/b/dest; latch `flag_carry` as carry-in; load counter with L−1, L = DIV_LATENCY (UDIV/SDIV/UMOD/SMOD), MUL_LATENCY (MUL), 1 otherwise (ADD, SUB, INC, DEC). NOP and unrecognised opcodes are accepted, produce no writeback, leave flags unchanged, and keep state IDLE.
- EXEC: `alu_*` outputs driven from latched registers, constant throughout. Counter decrements each cycle; at counter==0, capture `alu_result` and the three flags into holding registers, then go WB, or TRAP per Configuration.
- WB: `wb_valid`=1; `wb_dest`/`wb_data` stable until `wb_ready`. Handshake cycle: copy held flags to `flag_*`, go IDLE.
- TRAP: `trap_valid`=1 until `trap_ack`; flags and register file untouched; then IDLE.
- Outside EXEC: `alu_op`=NOP, `alu_a`=`alu_b`=0, `alu_carryIn`=0.
- Reset (any state, including mid-EXEC/WB/TRAP): state IDLE, in-flight op discarded without writeback. All outputs 0 except `in_ready`=1; `alu_op`=NOP; flags=0.

## Timing
- Accept on edge T. EXEC occupies cycles T+1..T+L. `wb_valid` is first high in cycle T+L+1.
- Throughput: one op per L+2 cycles with `wb_ready` held high. No overlap; `in_ready`=0 from T+1 until return to IDLE.
- Flags update on the writeback handshake edge. The next op accepted after that edge sees the new carry.
- `trap_ack` or `wb_ready` asserted in the entry cycle completes in that same cycle.

## Configuration
- `ALU_EXEC_DIVZERO_TRAP_EN` defined: a divide/mod op with `alu_divByZero`=1 at capture goes to TRAP. No writeback occurs and flags are unchanged.
- Undefined: no TRAP state, and `trap_valid` is tied to 0. Divide-by-zero goes to WB with `wb_data`=0, and the flags written are zero=1, carry=0, negitive=0.

## Test plan
- ADD 1+2, flags clear -> `wb_valid` at T+2, `wb_data`=3, flags 0/0/0.
- ADD −1+1 (flags clear), then ADD 1+2 -> first `wb_data`=0 with zero=1, carry=1; second `wb_data`=4 (carry consumed).
- UDIV 6/2, DIV_LATENCY=4 -> `alu_a`/`alu_b` stable for cycles T+1..T+4; `wb_valid` at T+5, `wb_data`=3.
- UDIV 6/0 with macro -> `trap_valid` at T+5, no `wb_valid`, flags unchanged; `trap_ack` returns to IDLE. Without macro -> `wb_data`=0, zero=1.
- MUL 2×3 with `wb_ready` low 3 cycles -> `wb_data`=6 held, `in_ready`=0 throughout, completes on `wb_ready`.
- `reset` in cycle T+2 of SDIV -> next cycle IDLE, `in_ready`=1, no `wb_valid`/`trap_valid`, flags 0.
